// File: rtl/mem_stage_lsu_pkg.sv
// Shared RV32I pipeline types: memory access width and LSU state encodings.
// Also holds the store lane formatter used by the MEM-stage LSU.
package rv32i_types;

    typedef enum logic [1:0] {
        mw_word = 2'd0,
        mw_byte = 2'd1,
        mw_half = 2'd2
    } mem_width_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    typedef struct packed {
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } store_fmt_t;

    // Encoding 3 is undefined in the control word and behaves as a word access.
    function automatic mem_width_t decode_width(input logic [1:0] t);
        case (t)
            2'd1:    return mw_byte;
            2'd2:    return mw_half;
            default: return mw_word;
        endcase
    endfunction

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    function automatic store_fmt_t format_store(input mem_width_t w, input logic [1:0] off,
                                                input logic [31:0] rs2);
        store_fmt_t f;
        case (w)
            mw_byte: begin
                f.wmask = 4'b0001 << off;
                f.wdata = {4{rs2[7:0]}};
            end
            mw_half: begin
                f.wmask = off[1] ? 4'b1100 : 4'b0011;
                f.wdata = {2{rs2[15:0]}};
            end
            default: begin
                f.wmask = 4'b1111;
                f.wdata = rs2;
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational load formatter: picks the addressed byte/half/word out of a cache word and extends it.
// Shared with the writeback forwarding path, so it carries no state.
module lsu_load_align
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      off_i,
    input  mem_width_t      width_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        byte_sign;
    logic        half_sign;

    always_comb begin
        case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
    end

    // Halfword selection uses only off[1]; an odd offset is truncated.
    assign half_sel  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    assign byte_sign = ~unsigned_i & byte_sel[7];
    assign half_sign = ~unsigned_i & half_sel[15];

    always_comb begin
        case (width_i)
            mw_byte: data_o = {{(XLEN-8){byte_sign}}, byte_sel};
            mw_half: data_o = {{(XLEN-16){half_sign}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: IDLE->BUSY->DONE held-request handshake, >=3 cycles accept to DONE; stall_o holds upstream until DONE.
// LSU_MISALIGN_TRAP_EN: misaligned half/word accesses skip the cache, finish with load_data_o=0 and raise misalign_o.
module mem_stage_lsu
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic            is_load_i,
    input  logic            is_store_i,
    input  logic [1:0]      load_type_i,
    input  logic            load_unsigned_i,
    input  logic [1:0]      store_type_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            pipe_advance_i,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_wmask,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_resp,
    output logic            stall_o,
    output logic [XLEN-1:0] load_data_o,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic            misalign_o,
`endif
    output logic            done_o
);

    lsu_state_t      state_q, state_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [3:0]      wmask_q, wmask_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [1:0]      off_q, off_d;
    mem_width_t      lwid_q, lwid_d;
    logic            luns_q, luns_d;
    logic [XLEN-1:0] ldata_q, ldata_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic            mis_q, mis_d;
    logic            misaligned;
    mem_width_t      acc_width;
`endif

    logic            mem_op;
    logic            is_wr;
    store_fmt_t      st_fmt;
    logic [XLEN-1:0] fmt_rdata;

    assign mem_op = valid_i & (is_load_i | is_store_i);
    // A control word with both bits set is handled as a store.
    assign is_wr  = is_store_i;
    assign st_fmt = format_store(decode_width(store_type_i), addr_i[1:0], wdata_i);

`ifdef LSU_MISALIGN_TRAP_EN
    assign acc_width  = is_wr ? decode_width(store_type_i) : decode_width(load_type_i);
    assign misaligned = ((acc_width == mw_half) & addr_i[0]) |
                        ((acc_width == mw_word) & (addr_i[1:0] != 2'b00));
`endif

    lsu_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata_i   (dmem_rdata),
        .off_i     (off_q),
        .width_i   (lwid_q),
        .unsigned_i(luns_q),
        .data_o    (fmt_rdata)
    );

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        done_d  = done_q;
        addr_d  = addr_q;
        wmask_d = wmask_q;
        wdata_d = wdata_q;
        off_d   = off_q;
        lwid_d  = lwid_q;
        luns_d  = luns_q;
        ldata_d = ldata_q;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    addr_d  = {addr_i[XLEN-1:2], 2'b00};
                    off_d   = addr_i[1:0];
                    lwid_d  = decode_width(load_type_i);
                    luns_d  = load_unsigned_i;
                    wmask_d = is_wr ? st_fmt.wmask : 4'b1111;
                    wdata_d = is_wr ? st_fmt.wdata : wdata_i;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        ldata_d = '0;
                        mis_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        rd_d    = ~is_wr;
                        wr_d    = is_wr;
                        state_d = BUSY;
                    end
`else
                    rd_d    = ~is_wr;
                    wr_d    = is_wr;
                    state_d = BUSY;
`endif
                end
            end
            BUSY: begin
                if (dmem_resp) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ldata_d = fmt_rdata;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (pipe_advance_i) begin
                    done_d  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    mis_d   = 1'b0;
`endif
                    state_d = IDLE;
                end
            end
            default: begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wmask_q <= 4'b0000;
            wdata_q <= '0;
            off_q   <= 2'b00;
            lwid_q  <= mw_word;
            luns_q  <= 1'b0;
            ldata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            wmask_q <= wmask_d;
            wdata_q <= wdata_d;
            off_q   <= off_d;
            lwid_q  <= lwid_d;
            luns_q  <= luns_d;
            ldata_q <= ldata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    // The request drops in the response cycle itself so the cache never sees a second beat.
    assign dmem_read   = rd_q & ~dmem_resp;
    assign dmem_write  = wr_q & ~dmem_resp;
    assign dmem_addr   = addr_q;
    assign dmem_wmask  = wmask_q;
    assign dmem_wdata  = wdata_q;
    assign load_data_o = ldata_q;
    assign done_o      = done_q;
    assign stall_o     = mem_op & (state_q != DONE);
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_o  = mis_q;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: expectations are queued per access and popped when the access completes.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n, valid_i, is_load_i, is_store_i, load_unsigned_i, pipe_advance_i, dmem_resp;
    logic [1:0]  load_type_i, store_type_i;
    logic [31:0] addr_i, wdata_i, dmem_rdata, dmem_addr, dmem_wdata, load_data_o;
    logic        dmem_read, dmem_write, stall_o, done_o;
    logic [3:0]  dmem_wmask;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_stage_lsu dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .is_load_i(is_load_i),
        .is_store_i(is_store_i), .load_type_i(load_type_i), .load_unsigned_i(load_unsigned_i),
        .store_type_i(store_type_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .pipe_advance_i(pipe_advance_i), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .stall_o(stall_o),
        .load_data_o(load_data_o),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign_o(misalign_o),
`endif
        .done_o(done_o)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic        wr;
        logic [31:0] ldata;
    } exp_t;

    typedef struct packed {
        logic        req, rd, wr, req_acc, req_done, unstable, overlap, gated, done, stall_done, mis;
        logic [31:0] addr, wdata, ldata;
        logic [3:0]  wmask;
        logic [15:0] stall_cnt, start, done_cyc;
    } obs_t;

    exp_t exp_q[$];

    function automatic exp_t model(input logic st, input logic [1:0] lt, input logic lu,
                                   input logic [1:0] stt, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rd);
        exp_t e;
        logic [31:0] sh;
        e = '0;
        e.addr  = {a[31:2], 2'b00};
        e.wr    = st;
        e.wmask = 4'hF;
        e.wdata = wd;
        if (st) begin
            if (stt == 2'd1) begin
                e.wmask = 4'b0001 << a[1:0];
                e.wdata = {4{wd[7:0]}};
            end else if (stt == 2'd2) begin
                e.wmask = a[1] ? 4'b1100 : 4'b0011;
                e.wdata = {2{wd[15:0]}};
            end
        end else if (lt == 2'd1) begin
            sh = rd >> {a[1:0], 3'b000};
            e.ldata = lu ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        end else if (lt == 2'd2) begin
            sh = a[1] ? (rd >> 16) : rd;
            e.ldata = lu ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        end else begin
            e.ldata = rd;
        end
        return e;
    endfunction

    // Drives one MEM-stage instruction from a negedge and answers the cache after dly request cycles.
    task automatic run_access(input logic ld, input logic st, input logic [1:0] lt, input logic lu,
                              input logic [1:0] stt, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int dly, output obs_t o);
        int nreq;
        o = '0;
        nreq = 0;
        valid_i = 1'b1; is_load_i = ld; is_store_i = st; load_type_i = lt; load_unsigned_i = lu;
        store_type_i = stt; addr_i = a; wdata_i = wd; dmem_rdata = rd;
        pipe_advance_i = 1'b1; dmem_resp = 1'b0;
        #1;
        o.stall_cnt = {15'd0, stall_o};
        o.req_acc   = dmem_read | dmem_write;
        for (int c = 0; c < 64 && !o.done; c++) begin
            @(negedge clk);
            dmem_resp = 1'b0;
            if (done_o) begin
                o.done       = 1'b1;
                o.ldata      = load_data_o;
                o.stall_done = stall_o;
                o.req_done   = dmem_read | dmem_write;
                o.done_cyc   = cyc[15:0];
`ifdef LSU_MISALIGN_TRAP_EN
                o.mis        = misalign_o;
`endif
            end else begin
                if (stall_o) o.stall_cnt = o.stall_cnt + 16'd1;
                if (dmem_read | dmem_write) begin
                    if (nreq == 0) begin
                        o.req = 1'b1; o.rd = dmem_read; o.wr = dmem_write; o.addr = dmem_addr;
                        o.wmask = dmem_wmask; o.wdata = dmem_wdata; o.start = cyc[15:0];
                    end else if (dmem_addr !== o.addr || dmem_wmask !== o.wmask ||
                                 dmem_wdata !== o.wdata || dmem_read !== o.rd) begin
                        o.unstable = 1'b1;
                    end
                    if (dmem_read & dmem_write) o.overlap = 1'b1;
                    nreq++;
                    if (nreq >= dly) begin
                        dmem_resp = 1'b1;
                        #1;
                        o.gated = ~(dmem_read | dmem_write);
                    end
                end
            end
        end
        if (o.done) begin
            @(posedge clk);
            @(negedge clk);
        end
        valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; dmem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; load_type_i = 2'd0;
        load_unsigned_i = 1'b0; store_type_i = 2'd0; addr_i = '0; wdata_i = '0;
        pipe_advance_i = 1'b0; dmem_rdata = '0; dmem_resp = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({dmem_read, dmem_write, done_o, stall_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got %b want 0000", {dmem_read, dmem_write, done_o, stall_o});
        end
        vectors++;
        if (dmem_wmask !== 4'b0000 || dmem_addr !== 32'd0) begin
            errors++; $display("FAIL reset_addr_mask got %h/%b want 0/0000", dmem_addr, dmem_wmask);
        end
        vectors++;
        if (dmem_wdata !== 32'd0 || load_data_o !== 32'd0) begin
            errors++; $display("FAIL reset_data got %h/%h want 0/0", dmem_wdata, load_data_o);
        end
`ifdef LSU_MISALIGN_TRAP_EN
        vectors++;
        if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign_o); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_byte();
        obs_t o;
        exp_t e;
        exp_q.push_back('{addr: 32'h1000, wmask: 4'b1000, wdata: 32'hA5A5A5A5, wr: 1'b1, ldata: 32'd0});
        run_access(1'b0, 1'b1, 2'd0, 1'b0, 2'd1, 32'h1003, 32'h000000A5, 32'd0, 2, o);
        e = exp_q.pop_front();
        vectors++;
        if (!(o.req && o.wr === e.wr && !o.rd)) begin
            errors++; $display("FAIL sb_dir got rd=%b wr=%b want write", o.rd, o.wr);
        end
        vectors++;
        if (o.addr !== e.addr || o.wmask !== e.wmask || o.wdata !== e.wdata) begin
            errors++; $display("FAIL sb_fmt got %h/%b/%h want %h/%b/%h", o.addr, o.wmask, o.wdata,
                               e.addr, e.wmask, e.wdata);
        end
        vectors++;
        if (o.stall_cnt !== 16'd3 || !o.done || o.stall_done !== 1'b0) begin
            errors++; $display("FAIL sb_stall got stall=%0d done=%b want 3 then done", o.stall_cnt, o.done);
        end
        vectors++;
        if (o.unstable || !o.gated || o.req_done) begin
            errors++; $display("FAIL sb_hold got unstable=%b gated=%b req_in_done=%b want 0/1/0",
                               o.unstable, o.gated, o.req_done);
        end
    endtask

    task automatic test_load_format();
        logic [1:0]  lt  [7] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1};
        logic        lu  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] a   [7] = '{32'h3002, 32'h3002, 32'h3002, 32'h3002, 32'h3000, 32'h3000, 32'h3000};
        logic [31:0] rd  [7] = '{32'h12F03456, 32'h12F03456, 32'h8001ABCD, 32'h8001ABCD,
                                 32'h8001ABCD, 32'h8001ABCD, 32'h00000080};
        logic [31:0] exl [7] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8001, 32'h00008001,
                                 32'h8001ABCD, 32'h8001ABCD, 32'hFFFFFF80};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back('{addr: 32'h3000, wmask: 4'hF, wdata: 32'd0, wr: 1'b0, ldata: exl[i]});
            run_access(1'b1, 1'b0, lt[i], lu[i], 2'd0, a[i], 32'd0, rd[i], 1, o);
            e = exp_q.pop_front();
            vectors++;
            if (o.ldata !== e.ldata || !o.done) begin
                errors++; $display("FAIL load_fmt[%0d] got %h done=%b want %h", i, o.ldata, o.done, e.ldata);
            end
            vectors++;
            if (!o.rd || o.wr || o.addr !== e.addr || o.wmask !== e.wmask || o.stall_cnt !== 16'd2) begin
                errors++; $display("FAIL load_req[%0d] got rd=%b addr=%h mask=%b stall=%0d want 1/%h/%b/2",
                                   i, o.rd, o.addr, o.wmask, o.stall_cnt, e.addr, e.wmask);
            end
        end
    endtask

    task automatic test_store_format();
        logic        ld  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [1:0]  stt [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
        logic [31:0] a   [4] = '{32'h1002, 32'h1004, 32'h1008, 32'h1001};
        logic [31:0] wd  [4] = '{32'h1234BEEF, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0000005A};
        obs_t o;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(model(1'b1, 2'd0, 1'b0, stt[i], a[i], wd[i], 32'd0));
            run_access(ld[i], 1'b1, 2'd0, 1'b0, stt[i], a[i], wd[i], 32'h0BADF00D, 1, o);
            e = exp_q.pop_front();
            vectors++;
            if (!o.wr || o.rd || o.addr !== e.addr || o.wmask !== e.wmask || o.wdata !== e.wdata) begin
                errors++; $display("FAIL store_fmt[%0d] got wr=%b %h/%b/%h want %h/%b/%h", i, o.wr,
                                   o.addr, o.wmask, o.wdata, e.addr, e.wmask, e.wdata);
            end
        end
    endtask

    task automatic test_random();
        obs_t o;
        exp_t e;
        logic st, lu;
        logic [1:0] ty, off;
        logic [31:0] a, wd, rd;
        int dly;
        for (int i = 0; i < 24; i++) begin
            st  = 1'($urandom_range(0, 1));
            ty  = 2'($urandom_range(0, 3));
            lu  = 1'($urandom_range(0, 1));
            off = (ty == 2'd1) ? 2'($urandom_range(0, 3)) : (ty == 2'd2) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
            a   = {$urandom(), 2'b00} | {30'd0, off};
            wd  = $urandom();
            rd  = $urandom();
            dly = $urandom_range(1, 3);
            exp_q.push_back(model(st, ty, lu, ty, a, wd, rd));
            run_access(~st, st, ty, lu, ty, a, wd, rd, dly, o);
            e = exp_q.pop_front();
            vectors++;
            if (o.wr !== e.wr || o.addr !== e.addr || o.wmask !== e.wmask ||
                (st && o.wdata !== e.wdata) || (!st && o.ldata !== e.ldata)) begin
                errors++; $display("FAIL rand[%0d] got wr=%b %h/%b/%h ld=%h want wr=%b %h/%b/%h ld=%h",
                                   i, o.wr, o.addr, o.wmask, o.wdata, o.ldata, e.wr, e.addr, e.wmask,
                                   e.wdata, e.ldata);
            end
            vectors++;
            if (o.stall_cnt !== 16'(dly + 1) || o.unstable || !o.done) begin
                errors++; $display("FAIL rand_hs[%0d] got stall=%0d unstable=%b done=%b want %0d/0/1",
                                   i, o.stall_cnt, o.unstable, o.done, dly + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        exp_t e;
        exp_q.push_back(model(1'b0, 2'd0, 1'b0, 2'd0, 32'h4000, 32'd0, 32'h5566_7788));
        exp_q.push_back(model(1'b1, 2'd0, 1'b0, 2'd0, 32'h4008, 32'h0102_0304, 32'd0));
        run_access(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h4000, 32'd0, 32'h5566_7788, 1, o1);
        run_access(1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 32'h4008, 32'h0102_0304, 32'hFFFF_0000, 1, o2);
        e = exp_q.pop_front();
        vectors++;
        if (o1.ldata !== e.ldata || !o1.rd) begin
            errors++; $display("FAIL b2b_lw got %h rd=%b want %h", o1.ldata, o1.rd, e.ldata);
        end
        e = exp_q.pop_front();
        vectors++;
        if (!o2.wr || o2.addr !== e.addr || o2.wdata !== e.wdata) begin
            errors++; $display("FAIL b2b_sw got wr=%b %h/%h want %h/%h", o2.wr, o2.addr, o2.wdata, e.addr, e.wdata);
        end
        vectors++;
        if (o2.start !== o1.done_cyc + 16'd2 || o2.req_acc || o1.req_done || o1.overlap || o2.overlap) begin
            errors++; $display("FAIL b2b_timing got start=%0d want %0d (req_acc=%b)", o2.start,
                               o1.done_cyc + 16'd2, o2.req_acc);
        end
    endtask

    task automatic test_reset_mid_busy();
        obs_t o;
        logic seen;
        seen = 1'b0;
        valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0; load_type_i = 2'd0;
        addr_i = 32'h5000; dmem_rdata = 32'h7777_7777; pipe_advance_i = 1'b1; dmem_resp = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            seen = dmem_read;
        end
        vectors++;
        if (!seen) begin errors++; $display("FAIL rst_busy_req got no read want read"); end
        rst_n = 1'b0; valid_i = 1'b0; is_load_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
            errors++; $display("FAIL rst_busy_drop got rd=%b wr=%b want 0/0", dmem_read, dmem_write);
        end
        dmem_resp = 1'b1;
        @(negedge clk);
        dmem_resp = 1'b0;
        vectors++;
        if (done_o !== 1'b0 || load_data_o !== 32'd0 || dmem_read !== 1'b0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL rst_busy_after got done=%b ld=%h rd=%b stall=%b want 0/0/0/0",
                               done_o, load_data_o, dmem_read, stall_o);
        end
        run_access(1'b1, 1'b0, 2'd2, 1'b1, 2'd0, 32'h5002, 32'd0, 32'hBEEF_0000, 1, o);
        vectors++;
        if (o.stall_cnt !== 16'd2 || o.ldata !== 32'h0000_BEEF) begin
            errors++; $display("FAIL rst_busy_idle got stall=%0d ld=%h want 2/0000beef", o.stall_cnt, o.ldata);
        end
    endtask

`ifdef LSU_MISALIGN_TRAP_EN
    task automatic test_misalign();
        obs_t o;
        exp_q.push_back('{addr: 32'h2000, wmask: 4'hF, wdata: 32'd0, wr: 1'b0, ldata: 32'd0});
        run_access(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h2002, 32'd0, 32'h1234_5678, 1, o);
        void'(exp_q.pop_front());
        vectors++;
        if (o.req || !o.done || o.mis !== 1'b1 || o.ldata !== 32'd0 || o.stall_cnt !== 16'd1) begin
            errors++; $display("FAIL misalign got req=%b done=%b mis=%b ld=%h stall=%0d want 0/1/1/0/1",
                               o.req, o.done, o.mis, o.ldata, o.stall_cnt);
        end
        vectors++;
        if (misalign_o !== 1'b0) begin errors++; $display("FAIL misalign_clear got %b want 0", misalign_o); end
    endtask
`else
    task automatic test_truncate();
        obs_t o;
        exp_t e;
        exp_q.push_back(model(1'b0, 2'd0, 1'b0, 2'd0, 32'h2002, 32'd0, 32'h1234_5678));
        run_access(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 32'h2002, 32'd0, 32'h1234_5678, 1, o);
        e = exp_q.pop_front();
        vectors++;
        if (!o.rd || o.addr !== e.addr || o.ldata !== e.ldata) begin
            errors++; $display("FAIL trunc_lw got rd=%b %h ld=%h want %h ld=%h", o.rd, o.addr, o.ldata, e.addr, e.ldata);
        end
        exp_q.push_back(model(1'b1, 2'd0, 1'b0, 2'd2, 32'h1001, 32'h0000_ABCD, 32'd0));
        run_access(1'b0, 1'b1, 2'd0, 1'b0, 2'd2, 32'h1001, 32'h0000_ABCD, 32'd0, 1, o);
        e = exp_q.pop_front();
        vectors++;
        if (o.wmask !== e.wmask || o.wdata !== e.wdata) begin
            errors++; $display("FAIL trunc_sh got %b/%h want %b/%h", o.wmask, o.wdata, e.wmask, e.wdata);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_store_byte();
        test_load_format();
        test_store_format();
        test_random();
        test_back_to_back();
`ifdef LSU_MISALIGN_TRAP_EN
        test_misalign();
`else
        test_truncate();
`endif
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
